// File: rtl/img_stream_source_pkg.sv
// img_stream_source_pkg: FSM state encoding, clog2 and window-stage latency for img_stream_source.
package img_stream_source_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // The 3x3 window stage needs one full row plus two pixels before its first result.
    function automatic int win_latency(input int img_width);
        return img_width + 2;
    endfunction
endpackage

// File: rtl/img_stream_source_if.sv
// img_stream_source_if: frame-control, RAM-read and pixel-stream signals of img_stream_source.
interface img_stream_source_if #(
    parameter int DW = 8,
    parameter int AW = 16
);
    logic          Start, Pause, RD_EN, Valid_OUT, Flush_OUT, Busy, Done;
    logic [AW-1:0] RD_Addr;
    logic [DW-1:0] RD_Data, Out;

    modport master (
        input  Start, Pause, RD_Data,
        output RD_EN, RD_Addr, Out, Valid_OUT, Flush_OUT, Busy, Done
    );
    modport slave (
        output Start, Pause, RD_Data,
        input  RD_EN, RD_Addr, Out, Valid_OUT, Flush_OUT, Busy, Done
    );
endinterface

// File: rtl/img_stream_source_stream_counter.sv
// img_stream_source_stream_counter: up-counter with load-to-zero, enable and terminal-count flag.
module img_stream_source_stream_counter #(
    parameter int           W    = 8,
    parameter logic [W-1:0] LAST = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // Holds at LAST so the count never wraps inside a frame.
    always_comb cnt_d = load_i ? '0 : (en_i && !tc_o) ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;

    assign cnt_o = cnt_q;
    assign tc_o  = cnt_q == LAST;
endmodule

// File: rtl/img_stream_source.sv
// img_stream_source: raster-scan RAM reader feeding the 3x3 window stage, then Flush_Len padding pixels.
// Build with FLUSH_REPLICATE_EN to pad with the frame's last real pixel instead of zero.
module img_stream_source
    import img_stream_source_pkg::*;
#(
    parameter int IMG_Width  = 256,
    parameter int IMG_Height = 256,
    parameter int Datawidth  = 8,
    parameter int Addrwidth  = 16,
    parameter int Flush_Len  = win_latency(IMG_Width)
) (
    input logic                 CLK,
    input logic                 CLR,
    img_stream_source_if.master bus
);
    localparam int N  = IMG_Width * IMG_Height;
    localparam int FW = clog2(Flush_Len + 1);

    state_t               state_q, state_d;
    logic                 pend_q, rd_en, fl_emit, addr_tc, fl_tc;
    logic [Addrwidth-1:0] addr;
    logic [FW-1:0]        fl_cnt_unused;
    logic [Datawidth-1:0] out_q, flush_val;

    img_stream_source_stream_counter #(.W(Addrwidth), .LAST(Addrwidth'(N - 1))) u_addr (
        .clk(CLK), .rst_n(CLR), .load_i(state_q == IDLE), .en_i(rd_en),
        .cnt_o(addr), .tc_o(addr_tc)
    );

    img_stream_source_stream_counter #(.W(FW), .LAST(FW'(Flush_Len - 1))) u_flush (
        .clk(CLK), .rst_n(CLR), .load_i(state_q != FLUSH), .en_i(fl_emit),
        .cnt_o(fl_cnt_unused), .tc_o(fl_tc)
    );

    always_comb begin
        rd_en   = state_q == READ && !bus.Pause;
        fl_emit = state_q == FLUSH && !pend_q && !bus.Pause;
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = bus.Start ? READ : IDLE;
            READ:  state_d = (rd_en && addr_tc) ? FLUSH : READ;
            FLUSH: state_d = (fl_emit && fl_tc) ? DONE : FLUSH;
            DONE:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= rd_en;
            out_q   <= bus.Out;
        end
    end

`ifdef FLUSH_REPLICATE_EN
    // Once real pixels stop, out_q only ever holds the last one.
    assign flush_val = out_q;
`else
    assign flush_val = '0;
`endif

    assign bus.RD_EN     = rd_en;
    assign bus.RD_Addr   = addr;
    assign bus.Out       = pend_q ? bus.RD_Data : fl_emit ? flush_val : out_q;
    assign bus.Valid_OUT = pend_q || fl_emit;
    assign bus.Flush_OUT = fl_emit;
    assign bus.Busy      = state_q inside {READ, FLUSH};
    assign bus.Done      = state_q == DONE;
endmodule

// File: tb/tb_img_stream_source.sv
// tb_img_stream_source: directed and randomized frames checked against a pixel-counting reference model.
module tb_img_stream_source;
    localparam int W = 4, H = 3, FL = 6, N = W * H, DW = 8, AW = 16;
`ifdef FLUSH_REPLICATE_EN
    localparam logic [DW-1:0] FLV = DW'(N);
`else
    localparam logic [DW-1:0] FLV = '0;
`endif

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    img_stream_source_if #(.DW(DW), .AW(AW)) bus ();

    img_stream_source #(
        .IMG_Width(W), .IMG_Height(H), .Datawidth(DW), .Addrwidth(AW), .Flush_Len(FL)
    ) dut (
        .CLK(clk), .CLR(clr), .bus(bus)
    );

    // Image RAM with mem[i] = i + 1 and one cycle of read latency.
    always @(posedge clk) if (bus.RD_EN) bus.RD_Data <= DW'(bus.RD_Addr + 1'b1);

    int n_tests = 0, n_fail = 0;
    bit m_act, m_done, m_pend, m_rst;
    int m_iss, m_fl, busy_n, done_n;
    logic [DW-1:0] m_out;
    logic [DW:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model tracks only how many reads were issued, how many pads emitted and whether a read is in flight.
    task automatic cycle(input logic st, input logic pa, input logic rn);
        logic e_rd, e_emit, e_val;
        logic [DW-1:0] e_out;
        bus.Start = st;
        bus.Pause = pa;
        clr = rn;
        e_rd   = m_act && m_iss < N && !pa;
        e_emit = m_act && m_iss == N && !m_pend && !pa;
        e_val  = m_pend || e_emit;
        e_out  = m_pend ? DW'(m_iss) : e_emit ? FLV : m_out;
        @(negedge clk);
        check("rd_en", bus.RD_EN, e_rd);
        if (e_rd || m_rst) check("rd_addr", bus.RD_Addr, m_rst ? 0 : m_iss);
        check("valid", bus.Valid_OUT, e_val);
        check("flush", bus.Flush_OUT, e_emit);
        check("out", bus.Out, e_out);
        check("busy", bus.Busy, m_act);
        check("done", bus.Done, m_done);
        busy_n += int'(bus.Busy);
        done_n += int'(bus.Done);
        if (bus.Valid_OUT) got_q.push_back({bus.Flush_OUT, bus.Out});
        @(posedge clk);
        m_rst = !rn;
        if (!rn) begin
            m_act = 0; m_done = 0; m_pend = 0; m_out = '0;
        end else begin
            if (e_val) m_out = e_out;
            m_pend = e_rd;
            if (m_done) m_done = 0;
            else if (!m_act) begin
                if (st) begin m_act = 1; m_iss = 0; m_fl = 0; end
            end else begin
                m_iss += int'(e_rd);
                if (e_emit) begin
                    m_fl++;
                    if (m_fl == FL) begin m_act = 0; m_done = 1; end
                end
            end
        end
        #1;
    endtask

    // mode 0 plain, 1 pause in [a,b], 2 random pause a%, 3 reset at a, 4 Start pulse at a and high from b.
    task automatic frame(input string nm, input int mode, input int a, input int b, input int exp_busy);
        logic st, pa, rn;
        busy_n = 0;
        done_n = 0;
        got_q.delete();
        cycle(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 300; k++) begin
            st = (mode == 4) ? (k == a || k >= b) : (mode == 2) ? 1'($urandom_range(1)) : 1'b0;
            pa = (mode == 1) ? (k >= a && k <= b) : (mode == 2) ? ($urandom_range(99) < a) : 1'b0;
            rn = !(mode == 3 && k == a);
            cycle(st, pa, rn);
            if (done_n > 0 || (mode == 3 && k > a)) break;
        end
        check($sformatf("%s.done_pulses", nm), done_n, mode == 3 ? 0 : 1);
        if (exp_busy > 0) check($sformatf("%s.busy_cycles", nm), busy_n, exp_busy);
        if (mode != 3) begin
            check($sformatf("%s.stream_len", nm), got_q.size(), N + FL);
            foreach (got_q[i])
                check($sformatf("%s.pix%0d", nm, i), got_q[i], i < N ? {1'b0, DW'(i + 1)} : {1'b1, FLV});
        end
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.Pause = 1'b0;
        clr = 1'b0;
        m_out = '0;
        repeat (2) @(posedge clk);
        #1;
        m_rst = 1;
        frame("plain", 0, 0, 0, N + 1 + FL);
        frame("rd_pause", 1, 5, 6, N + 1 + FL + 2);
        frame("fl_pause", 1, 14, 16, N + 1 + FL + 3);
        frame("flush_rst", 3, 15, 0, -1);
        frame("after_rst", 0, 0, 0, N + 1 + FL);
        frame("start_held", 4, 7, 17, N + 1 + FL);
        frame("retrigger", 0, 0, 0, N + 1 + FL);
        repeat (6) begin
            repeat ($urandom_range(3)) cycle(1'b0, 1'($urandom_range(1)), 1'b1);
            frame("random", 2, 35, 0, -1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/img_stream_source.md
Name: img_stream_source

Overview:
- Raster-scan pixel transmitter that feeds the 3x3 window line-buffer stage.
- Reads a frame from a synchronous image RAM with 1-cycle read latency and emits one pixel per cycle on Out/Valid_OUT. These connect to the window stage's In/Valid_IN.
- After the last real pixel it emits Flush_Len padding pixels. The window pipeline only advances on valid input, so this padding is what drains the final window results out of it.
- Start/Busy/Done control handshake toward the frame controller.

Parameters:
- IMG_Width, 256, pixels per row.
- IMG_Height, 256, rows per frame.
- Datawidth, 8, bits per pixel.
- Addrwidth, 16, RAM address width; must satisfy 2^Addrwidth >= IMG_Width*IMG_Height.
- Flush_Len, IMG_Width+2, padding pixels emitted after the frame; must equal the window stage's valid latency.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- CLR  in  1  reset; synchronous, active-low.
- Start  in  1  frame request; sampled only in IDLE.
- Pause  in  1  hold; while high, no new RAM read is issued and no flush pixel is emitted.
- RD_EN  out  1  RAM read strobe.
- RD_Addr  out  Addrwidth  RAM read address.
- RD_Data  in  Datawidth  RAM data, valid the cycle after RD_EN.
- Out  out  Datawidth  pixel to the window stage.
- Valid_OUT  out  1  Out qualifier.
- Flush_OUT  out  1  high with Valid_OUT when Out is a padding pixel.
- Busy  out  1  high in READ and FLUSH.
- Done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (CLR=0 at an edge): state IDLE, and all outputs and counters are 0. This applies mid-frame too: any in-flight read is discarded and no Done pulse is generated.
- States: IDLE, READ, FLUSH, DONE. N = IMG_Width*IMG_Height.
- IDLE:
  - Start=1 at edge: go to READ; address counter is 0.
  - Start=0: stay in IDLE.
- READ:
  - Each cycle with Pause=0: RD_EN=1, RD_Addr=addr, then addr increments.
  - Cycle with Pause=1: RD_EN=0, addr holds.
  - After issuing addr N-1 (Pause=0): go to FLUSH.
- Read data path:
  - A pending flag is set in any cycle RD_EN=1.
  - The following cycle: Out=RD_Data, Valid_OUT=1, Flush_OUT=0.
  - Pause arriving while a read is pending does not suppress that delivery.
  - Read-to-output latency is exactly 1 cycle.
- FLUSH:
  - The first cycle delivers the pending last real pixel if one exists. Flush emission is blocked in any cycle with a pending read.
  - Otherwise, each cycle with Pause=0: Out=flush value, Valid_OUT=1, Flush_OUT=1, flush counter increments.
  - After the Flush_Len-th flush pixel: go to DONE.
- DONE: Done=1, Busy=0 for one cycle, then IDLE.
- Start while not in IDLE is ignored. Start held high re-triggers a new frame on the first IDLE cycle after DONE.
- Counters:
  - addr counter is Addrwidth bits and never wraps within a frame.
  - flush counter is clog2(Flush_Len+1) bits.
- Valid_OUT=0 in every cycle that delivers no pixel. Out holds its last value; no bubble value is defined.
- Minimal frame with no Pause: Busy high for N+1+Flush_Len cycles; Done one cycle later.

Optional Feature:
- Macro FLUSH_REPLICATE_EN.
- Defined: the flush value is the last real pixel of the frame, captured when delivered.
- Undefined: the flush value is all-zero.
- Flush_OUT, counts and timing are identical in both builds.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, READ=2'd1, FLUSH=2'd2, DONE=2'd3) and a clog2 function. Window-stage latency is expressed there as a constant derived from IMG_Width, and is the default source for Flush_Len.
- One natural sub-module: stream_counter (load-zero, enable, terminal-count flag). It is instantiated twice, for addr and for flush count.

Test Plan:
All scenarios use IMG_Width=4, IMG_Height=3, Flush_Len=6, RAM mem[i]=i+1.
1. Reset, then a one-cycle Start, Pause=0 -> RD_Addr 0..11 on consecutive cycles. Out 1..12 with Valid_OUT one cycle after each read. Then 6 zero pixels with Flush_OUT=1. Busy high for 19 cycles, then Done high for exactly 1 cycle.
2. Pause=1 during the cycles in which addr 5 would issue and the following cycle -> RD_EN low for 2 cycles. Pixel 5 (read in the preceding cycle) is still delivered during the pause. The stream shows 1..12 with no loss or duplication, and Done is 2 cycles later than in scenario 1.
3. Pause=1 for 3 cycles during FLUSH -> still exactly 6 flush pixels in total, and Done is 3 cycles later than in scenario 1.
4. CLR=0 for one cycle during FLUSH -> next cycle all outputs are 0 and the state is IDLE, with no Done pulse. A subsequent Start replays the full frame from addr 0.
5. Start pulsed at cycle 7 of READ and held high through DONE -> the mid-frame pulse is ignored. A second frame begins the cycle after DONE, with RD_Addr=0.
6. FLUSH_REPLICATE_EN defined, scenario 1 repeated -> the 6 flush pixels equal 12, with Flush_OUT=1.
